// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and owner-index width
//   state_t       : arbiter FSM encoding (IDLE, GRANT, GAP)
//   dec3to8       : 3-to-8 one-hot decoder used to form the grant vector
package rr_arb_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] dec3to8(input logic [IDX_W-1:0] sel);
    logic [N_REQ-1:0] y;
    y      = '0;
    y[sel] = 1'b1;
    return y;
  endfunction

endpackage

// File: rtl/rr_arb_8_pick.sv
// rr_pick8: combinational round-robin picker.
//   req   [7:0] in  : request vector
//   start [2:0] in  : index with highest priority this round
//   any         out : at least one request present
//   idx   [2:0] out : winning requester, first set bit at or after start (wrapping)
// The request vector is rotated so that 'start' lands on bit 0, the lowest set bit
// is priority-encoded, and the offset is rotated back by adding 'start'.
module rr_pick8
  import rr_arb_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + start];
    end
    // Descending scan so the lowest set bit wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any = |rot;
    idx = off + start;
  end

endmodule

// File: rtl/rr_arb_8.sv
// rr_arb_8: 8-requester round-robin arbiter driving a shared resource through a
// 3-to-8 decoder. Holds the grant while the owner keeps requesting, preempts after
// MAX_HOLD cycles when others wait, and inserts one idle cycle between owners.
//   clk       in      : rising-edge clock
//   rst       in      : synchronous active-high reset
//   req       in  [7] : level-sensitive request, bit i = requester i
//   gnt       out [7] : registered one-hot grant, zero when no owner
//   gnt_valid out     : gnt != 0
//   gnt_idx   out [3] : binary owner index, 0 when no owner
//   dec_sel   out [3] : decoder select, mirrors gnt_idx
//   dec_en_n  out     : decoder enable, active-low, equals ~gnt_valid
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] dec_sel,
  output logic             dec_en_n
);

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] start_p0;
  logic             win_any_p0;
  logic [IDX_W-1:0] win_idx_p0;
  logic [N_REQ-1:0] win_gnt_p0;
  logic             owner_req_p0;
  logic             others_req_p0;
  logic             hold_max_p0;

  // Stage p0: next-owner selection from the live request vector
  assign start_p0 = last + IDX_W'(1);

  rr_pick8 u_pick (
    .req   (req),
    .start (start_p0),
    .any   (win_any_p0),
    .idx   (win_idx_p0)
  );

  assign win_gnt_p0    = dec3to8(win_idx_p0);
  assign owner_req_p0  = req[gnt_idx];
  assign others_req_p0 = |(req & ~gnt);
  assign hold_max_p0   = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Stage p1: FSM, hold counter, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= IDX_W'(N_REQ - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      dec_sel   <= '0;
      dec_en_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (win_any_p0) begin
            state     <= ST_GRANT;
            last      <= win_idx_p0;
            hold_cnt  <= '0;
            gnt       <= win_gnt_p0;
            gnt_valid <= 1'b1;
            gnt_idx   <= win_idx_p0;
            dec_sel   <= win_idx_p0;
            dec_en_n  <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            dec_sel   <= '0;
            dec_en_n  <= 1'b1;
          end
        end
        ST_GRANT: begin
          // A drop takes precedence over timeout; both end in GAP.
          if (!owner_req_p0 || (hold_max_p0 && others_req_p0)) begin
            state     <= ST_GAP;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            dec_sel   <= '0;
            dec_en_n  <= 1'b1;
          end else if (hold_max_p0) begin
            // Sole requester: restart the hold window without a gap.
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          hold_cnt  <= '0;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_idx   <= '0;
          dec_sel   <= '0;
          dec_en_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_8.sv
// Scoreboard bench for rr_arb_8: the stimulus process pushes the expected grant
// for the cycle after each edge; a monitor pops and compares on the falling edge
// and checks the output invariants every cycle.
module tb_rr_arb_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [2:0] dec_sel;
  logic       dec_en_n;

  always #5 clk = ~clk;

  rr_arb_8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .dec_sel   (dec_sel),
    .dec_en_n  (dec_en_n)
  );

  typedef struct {
    int         due;
    logic [7:0] gnt;
    string      name;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    cyc_n    = 0;
  int    checks   = 0;
  int    failures = 0;
  string tag      = "init";

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Apply inputs for the next edge and record the grant expected after it.
  task automatic cyc(input logic [7:0] r, input logic rs, input logic [7:0] eg);
    exp_t e;
    req   = r;
    rst   = rs;
    e.due = cyc_n + 1;
    e.gnt = eg;
    e.name = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc_n > 0) begin
      checks++;
      if ($countones(gnt) > 1 || gnt_valid !== (gnt != 8'h00) ||
          dec_en_n !== ~gnt_valid || dec_sel !== gnt_idx ||
          (gnt_valid && gnt !== (8'h01 << gnt_idx)) ||
          (!gnt_valid && gnt_idx !== 3'd0)) begin
        failures++;
        $display("FAIL invariant cyc=%0d gnt=%h valid=%b idx=%0d sel=%0d en_n=%b",
                 cyc_n, gnt, gnt_valid, gnt_idx, dec_sel, dec_en_n);
      end
      if (q.size() > 0 && q[0].due <= cyc_n) begin
        mon_e = q.pop_front();
        checks++;
        if (mon_e.due != cyc_n || gnt !== mon_e.gnt || gnt_idx !== idx_of(mon_e.gnt) ||
            gnt_valid !== (mon_e.gnt != 8'h00) || dec_en_n !== (mon_e.gnt == 8'h00)) begin
          failures++;
          $display("FAIL %s cyc=%0d got gnt=%h idx=%0d valid=%b en_n=%b expected gnt=%h idx=%0d",
                   mon_e.name, cyc_n, gnt, gnt_idx, gnt_valid, dec_en_n,
                   mon_e.gnt, idx_of(mon_e.gnt));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    #1;

    // Reset with all requesting, then release: req0 wins first.
    tag = "reset";
    cyc(8'hFF, 1'b1, 8'h00);
    cyc(8'hFF, 1'b1, 8'h00);
    tag = "reset_release";
    cyc(8'hFF, 1'b0, 8'h01);
    cyc(8'h00, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    // Single owner 4, then drop -> GAP -> IDLE.
    tag = "single";
    cyc(8'h10, 1'b0, 8'h10);
    cyc(8'h10, 1'b0, 8'h10);
    cyc(8'h10, 1'b0, 8'h10);
    cyc(8'h00, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    // Rotation 0..7,0 from a fresh pointer; each owner drops after 3 cycles.
    tag = "rot_reset";
    cyc(8'h00, 1'b1, 8'h00);
    tag = "rotation";
    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << (i % 8);
      cyc(8'hFF, 1'b0, oh);
      cyc(8'hFF, 1'b0, oh);
      cyc(8'hFF, 1'b0, oh);
      cyc(8'hFF & ~oh, 1'b0, 8'h00);
    end
    cyc(8'h00, 1'b0, 8'h00);

    // Timeout: 16 cycles of req0, GAP, 16 cycles of req1, GAP.
    tag = "to_reset";
    cyc(8'h00, 1'b1, 8'h00);
    tag = "timeout0";
    for (int i = 0; i < 16; i++) cyc(8'h03, 1'b0, 8'h01);
    tag = "timeout_gap0";
    cyc(8'h03, 1'b0, 8'h00);
    tag = "timeout1";
    for (int i = 0; i < 16; i++) cyc(8'h03, 1'b0, 8'h02);
    tag = "timeout_gap1";
    cyc(8'h03, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    // Sole owner 7 keeps the grant past the hold limit.
    tag = "sole";
    for (int i = 0; i < 40; i++) cyc(8'h80, 1'b0, 8'h80);
    cyc(8'h00, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    // Reset during a grant to 3: no GAP, pointer back to 7 so 0 wins next.
    tag = "midrst_own";
    cyc(8'h08, 1'b0, 8'h08);
    cyc(8'h08, 1'b0, 8'h08);
    cyc(8'h08, 1'b0, 8'h08);
    tag = "midrst";
    cyc(8'h08, 1'b1, 8'h00);
    tag = "midrst_after";
    cyc(8'h09, 1'b0, 8'h01);
    cyc(8'h09, 1'b0, 8'h01);
    cyc(8'h08, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    // Non-owner changes during GRANT do not move the grant.
    tag = "nonowner";
    cyc(8'h20, 1'b0, 8'h20);
    cyc(8'h21, 1'b0, 8'h20);
    cyc(8'h60, 1'b0, 8'h20);
    cyc(8'h00, 1'b0, 8'h00);
    cyc(8'h00, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
